ro_race_counter: RTL and testbench

//   Upstream race stage of the RO-PUF challenge path. It enables a pair of ring oscillators and counts

---
 rtl/ro_race_counter.sv | 176 +++++++++++++++++
 tb/tb_ro_race_counter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ro_race_counter.sv
// Race stage of the RO-PUF challenge path: two synchronised ring oscillators are counted in
// the clk domain until one count saturates or the watchdog expires; results are held in DONE.
module ro_race_counter #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TMO_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic             response,
  output logic             tie,
  output logic             timeout
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RACE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d, sync_b_q, sync_b_d;
  logic                   prev_a_q, prev_a_d, prev_b_q, prev_b_d;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic [TMO_W-1:0]       wdog_q, wdog_d;
  logic [CNT_W-1:0]       count_a_q, count_a_d, count_b_q, count_b_d;
  logic                   ro_en_q, ro_en_d, busy_q, busy_d, done_q, done_d;
  logic                   response_q, response_d, tie_q, tie_d, timeout_q, timeout_d;

  logic             edge_a_s, edge_b_s, sat_a_s, sat_b_s;
  logic [CNT_W-1:0] nxt_a_s, nxt_b_s;
  logic [TMO_W-1:0] wdog_inc_s;

  assign sync_a_d   = {sync_a_q[SYNC_STAGES-2:0], ro_a};
  assign sync_b_d   = {sync_b_q[SYNC_STAGES-2:0], ro_b};
  assign prev_a_d   = sync_a_q[SYNC_STAGES-1];
  assign prev_b_d   = sync_b_q[SYNC_STAGES-1];
  assign edge_a_s   = sync_a_q[SYNC_STAGES-1] & ~prev_a_q;
  assign edge_b_s   = sync_b_q[SYNC_STAGES-1] & ~prev_b_q;
  // A saturated counter never advances, so counts cannot wrap.
  assign nxt_a_s    = count_a_q + {{(CNT_W-1){1'b0}}, (edge_a_s && (count_a_q != CNT_MAX))};
  assign nxt_b_s    = count_b_q + {{(CNT_W-1){1'b0}}, (edge_b_s && (count_b_q != CNT_MAX))};
  assign sat_a_s    = (nxt_a_s == CNT_MAX);
  assign sat_b_s    = (nxt_b_s == CNT_MAX);
  assign wdog_inc_s = wdog_q + {{(TMO_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    wdog_d     = wdog_q;
    count_a_d  = count_a_q;
    count_b_d  = count_b_q;
    ro_en_d    = ro_en_q;
    busy_d     = busy_q;
    done_d     = done_q;
    response_d = response_q;
    tie_d      = tie_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_ARM;
          arm_cnt_d  = {ARM_W{1'b0}};
          wdog_d     = {TMO_W{1'b0}};
          count_a_d  = {CNT_W{1'b0}};
          count_b_d  = {CNT_W{1'b0}};
          ro_en_d    = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          response_d = 1'b0;
          tie_d      = 1'b0;
          timeout_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_ARM: begin
        if (arm_cnt_q == ARM_LAST) begin
          state_d = ST_RACE;
          wdog_d  = {TMO_W{1'b0}};
        end else begin
          arm_cnt_d = arm_cnt_q + {{(ARM_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RACE: begin
        wdog_d    = wdog_inc_s;
        count_a_d = nxt_a_s;
        count_b_d = nxt_b_s;
        // Saturation is checked first so it wins over a coincident watchdog expiry.
        if (sat_a_s || sat_b_s) begin
          state_d    = ST_DONE;
          ro_en_d    = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          response_d = sat_a_s & ~sat_b_s;
          tie_d      = sat_a_s & sat_b_s;
        end else if (wdog_inc_s == TMO_MAX) begin
          state_d    = ST_DONE;
          ro_en_d    = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          response_d = 1'b0;
          timeout_d  = 1'b1;
        end else begin
          state_d = ST_RACE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ro_en_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sync_a_q   <= {SYNC_STAGES{1'b0}};
      sync_b_q   <= {SYNC_STAGES{1'b0}};
      prev_a_q   <= 1'b0;
      prev_b_q   <= 1'b0;
      arm_cnt_q  <= {ARM_W{1'b0}};
      wdog_q     <= {TMO_W{1'b0}};
      count_a_q  <= {CNT_W{1'b0}};
      count_b_q  <= {CNT_W{1'b0}};
      ro_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      response_q <= 1'b0;
      tie_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_a_q   <= sync_a_d;
      sync_b_q   <= sync_b_d;
      prev_a_q   <= prev_a_d;
      prev_b_q   <= prev_b_d;
      arm_cnt_q  <= arm_cnt_d;
      wdog_q     <= wdog_d;
      count_a_q  <= count_a_d;
      count_b_q  <= count_b_d;
      ro_en_q    <= ro_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      response_q <= response_d;
      tie_q      <= tie_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ro_en    = ro_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count_a  = count_a_q;
  assign count_b  = count_b_q;
  assign response = response_q;
  assign tie      = tie_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_ro_race_counter.sv
// Directed bench for ro_race_counter (CNT_W=4, SYNC_STAGES=2, TMO_W=8); inputs and samples on negedge.
module tb_ro_race_counter;

  logic       clk = 1'b0;
  logic       rst, start, ro_a, ro_b;
  logic       ro_en, busy, done, response, tie, timeout;
  logic [3:0] count_a, count_b;

  int checks   = 0;
  int failures = 0;
  int tick     = 0;
  int t0       = 0;
  int mode     = 0;
  int per_a    = 0;
  int per_b    = 0;
  int bcyc     = 0;
  bit ok       = 1'b0;

  always #5 clk = ~clk;

  ro_race_counter #(.CNT_W(4), .SYNC_STAGES(2), .TMO_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en), .busy(busy), .done(done), .count_a(count_a), .count_b(count_b),
    .response(response), .tie(tie), .timeout(timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic wave(input int t, input int per);
    if (per == 0) return 1'b0;
    return (t % per) < (per / 2);
  endfunction

  // One clock: wait for negedge, then update the oscillator inputs.
  task automatic step();
    int k;
    @(negedge clk);
    tick++;
    k = tick - t0;
    case (mode)
      1: begin ro_a = wave(tick, per_a); ro_b = wave(tick, per_b); end
      // Fifteen B rises, the last first sampled on the 256th edge after start.
      2: begin ro_a = 1'b0; ro_b = (k >= 200) && (k <= 257) && (((k - 200) % 4) < 2); end
      default: begin ro_a = 1'b0; ro_b = 1'b0; end
    endcase
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    t0 = tick;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int busy_cycles, output bit got_done);
    busy_cycles = 0;
    got_done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      step();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ro_a = 1'b0; ro_b = 1'b0;
    mode = 1; per_a = 4; per_b = 6;
    repeat (3) step();
    check_eq("reset_state", {ro_en, busy, done, response, tie, timeout, count_a, count_b}, 32'd0);
    rst = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_eq("idle_after_rst", {ro_en, busy, done}, 32'd0);

    // Scenario 1: A period 4, B period 6.
    pulse_start();
    check_eq("t1_latency_ro_en", {ro_en, busy, done}, 32'b110);
    wait_done(400, bcyc, ok);
    check_eq("t1_done", ok, 1'b1);
    check_eq("t1_response", response, 1'b1);
    check_eq("t1_count_a", count_a, 4'd15);
    check_eq("t1_count_b_range", (count_b >= 4'd9) && (count_b <= 4'd10), 1'b1);
    check_eq("t1_flags", {ro_en, busy, tie, timeout}, 32'd0);
    repeat (5) step();
    check_eq("t1_hold", {done, response, count_a}, {1'b1, 1'b1, 4'd15});

    // Scenario 4: start mid-race is ignored, start in DONE restarts.
    pulse_start();
    repeat (20) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("t4_midstart_ignored", {busy, done}, 32'b10);
    wait_done(400, bcyc, ok);
    check_eq("t4_done", ok, 1'b1);
    check_eq("t4_result", {response, tie, timeout, count_a}, {1'b1, 1'b0, 1'b0, 4'd15});
    check_eq("t4_count_b_range", (count_b >= 4'd9) && (count_b <= 4'd10), 1'b1);
    pulse_start();
    check_eq("t4_restart_clear", {ro_en, busy, done, response, count_a, count_b}, {4'b1100, 8'd0});
    wait_done(400, bcyc, ok);
    check_eq("t4_rerun", {ok, response, count_a}, {1'b1, 1'b1, 4'd15});

    // Scenario 2: identical waveforms give a tie.
    per_b = 4;
    pulse_start();
    wait_done(400, bcyc, ok);
    check_eq("t2_done", ok, 1'b1);
    check_eq("t2_result", {tie, response, timeout, count_a, count_b}, {1'b1, 1'b0, 1'b0, 4'd15, 4'd15});

    // Scenario 3: no edges, watchdog expiry after 255 race cycles.
    mode = 0;
    pulse_start();
    wait_done(600, bcyc, ok);
    check_eq("t3_done", ok, 1'b1);
    check_eq("t3_busy_cycles", bcyc, 32'd258);
    check_eq("t3_result", {timeout, response, tie, count_a, count_b}, {1'b1, 1'b0, 1'b0, 8'd0});

    // Scenario 6: B saturates on the watchdog expiry edge.
    pulse_start();
    mode = 2;
    wait_done(600, bcyc, ok);
    check_eq("t6_done", ok, 1'b1);
    check_eq("t6_busy_cycles", bcyc, 32'd258);
    check_eq("t6_result", {timeout, response, tie, count_a, count_b}, {1'b0, 1'b0, 1'b0, 4'd0, 4'd15});

    // Scenario 5: asynchronous reset mid-race.
    mode = 1; per_a = 4; per_b = 6;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (count_a == 4'd7) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check_eq("t5_reached_7", ok, 1'b1);
    #2 rst = 1'b1;
    #1 check_eq("t5_async_clear", {ro_en, busy, done, response, tie, timeout, count_a, count_b}, 32'd0);
    step();
    step();
    rst = 1'b0;
    repeat (30) step();
    check_eq("t5_stays_idle", {ro_en, busy, done, count_a, count_b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
